// File: rtl/l2_writeback_buffer.sv
// Victim-line write-back buffer between the L2 and physical memory.
// Circular FIFO of evicted dirty lines, drained one write at a time, with lookup for L2 misses.
module l2_writeback_buffer #(
    parameter int unsigned width = 128,
    parameter int unsigned depth = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_valid,
    input  logic [15:0]      wb_addr,
    input  logic [width-1:0] wb_data,
    output logic             wb_ready,
    input  logic [15:0]      lk_addr,
    output logic             lk_hit,
    output logic [width-1:0] lk_data,
    output logic             pmem_write,
    output logic [15:0]      pmem_address,
    output logic [width-1:0] pmem_wdata,
    input  logic             pmem_resp,
    output logic             empty
);

    localparam int unsigned aw    = (depth > 1) ? $clog2(depth) : 1;
    localparam int unsigned cw    = aw + 1;
    localparam int unsigned tag_w = 12;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    logic [tag_w-1:0] tag_q  [depth];
    logic [width-1:0] data_q [depth];
    logic [aw-1:0]    head_q;
    logic [aw-1:0]    tail_q;
    logic [cw-1:0]    count_q;
    state_t           state_q;
    state_t           state_d;
    logic             push;
    logic             pop;
    logic             unused_addr_bits;

    // Line offset bits never participate in storage or matching.
    assign unused_addr_bits = ^{wb_addr[3:0], lk_addr[3:0]};

    assign wb_ready = (count_q != cw'(depth));
    assign push     = wb_valid && wb_ready;
    assign pop      = (state_q == WRITE) && pmem_resp;

    assign pmem_address = {tag_q[head_q], 4'b0000};
    assign pmem_wdata   = data_q[head_q];
    assign empty        = (count_q == '0) && (state_q == IDLE);

    // Line storage is left uncleared on reset; validity comes from count.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_q[tail_q]  <= wb_addr[15:4];
            data_q[tail_q] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
            if (push) begin
                tail_q <= tail_q + aw'(1);
            end
            if (pop) begin
                head_q <= head_q + aw'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + cw'(1);
                2'b01:   count_q <= count_q - cw'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Drain FSM: one write per line, returning to IDLE for a bubble after each response.
    always_comb begin
        state_d    = state_q;
        pmem_write = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                pmem_write = 1'b1;
                if (pmem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan oldest to newest so the newest matching entry wins.
    always_comb begin
        logic [aw-1:0] idx;
        lk_hit  = 1'b0;
        lk_data = '0;
        idx     = '0;
        for (int unsigned i = 0; i < depth; i++) begin
            idx = head_q + aw'(i);
            if ((cw'(i) < count_q) && (tag_q[idx] == lk_addr[15:4])) begin
                lk_hit  = 1'b1;
                lk_data = data_q[idx];
            end
        end
    end

endmodule
